fp_operand_loader: RTL and testbench
====================================

FP_OPERAND_LOADER -- requirements
Module: fp_operand_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1-255: idle cycles allowed mid-assembly before a partial operand pair is discarded.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_data  input  32  operand word from upstream.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  loader can accept a word.
REQ-007 SHALL have port a  output  64  IEEE-754 double operand A to floating_point_adder.
REQ-008 SHALL have port b  output  64  IEEE-754 double operand B to floating_point_adder.
REQ-009 SHALL have port out_valid  output  1  a/b complete and valid.
REQ-010 SHALL have port out_ready  input  1  downstream adder stage takes a/b.
REQ-011 SHALL have port err_timeout  output  1  one-cycle pulse on discarded partial pair.

Function
REQ-012 SHALL accept a word on any rising edge where in_valid && in_ready.
REQ-013 SHALL map accepted words in order: word0->a[31:0], word1->a[63:32], word2->b[31:0], word3->b[63:32].
REQ-014 SHALL implement states IDLE (0 words), LOAD (1-3 words), FULL (pair held).
REQ-015 SHALL transition IDLE->LOAD on word0, LOAD->FULL on word3, FULL->IDLE on out_valid && out_ready.
REQ-016 SHALL drive in_ready = 1 in IDLE and LOAD, 0 in FULL; no word accepted in the same cycle as the output handshake.
REQ-017 SHALL assert out_valid the cycle after word3 is accepted (1-cycle latency) and hold it until out_ready.
REQ-018 SHALL hold a and b stable while out_valid && !out_ready; a and b retain their last values after handshake.
REQ-019 SHALL run an 8-bit idle counter in LOAD only: clears on each accepted word, increments on each cycle without acceptance.
REQ-020 SHALL, when the idle counter reaches TIMEOUT_CYCLES, discard partial words, go to IDLE, and pulse err_timeout for exactly one cycle.
REQ-021 SHALL not time out in IDLE or FULL, regardless of stall length.
REQ-022 SHALL give acceptance priority over timeout: a word accepted in the timeout cycle keeps assembly alive and clears the counter.

Reset
REQ-023 SHALL, while rst is high, force state IDLE, word count 0, idle counter 0, a = 0, b = 0, out_valid = 0, err_timeout = 0, in_ready = 0.
REQ-024 SHALL, on rst asserted mid-assembly or in FULL, discard all words immediately with no err_timeout pulse.
REQ-025 SHALL drive in_ready = 1 the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, with macro FP_CLASSIFY_EN defined, add outputs a_class and b_class (3 bits each), registered with out_valid: 000 zero, 001 subnormal, 010 normal, 011 infinity, 100 quiet NaN, 101 signalling NaN; reset value 000.
REQ-027 SHALL, without FP_CLASSIFY_EN, omit a_class/b_class ports and classification logic entirely; all other behaviour identical.

Verification
REQ-028 SHALL cover: words 0x33333333, 0x3FF33333, 0x00000000, 0x3FF80000 back-to-back, out_ready=1 -> a=0x3FF3333333333333 (1.2), b=0x3FF8000000000000 (1.5), out_valid one cycle after word3, in_ready=1 the cycle after handshake.
REQ-029 SHALL cover: pair 1.2 / -2.0 (b=0xC000000000000000), out_ready held 0 for 10 cycles -> out_valid, a, b stable, in_ready=0 throughout, release completes one transfer.
REQ-030 SHALL cover: TIMEOUT_CYCLES=4, two words then in_valid=0 -> err_timeout pulses once on 4th idle cycle, next 4 words form a fresh pair 1.2 / 3.0E-3 (b=0x3F689374BC6A7EFA).
REQ-031 SHALL cover: rst asserted after word2 -> out_valid=0, a=b=0 asynchronously, no err_timeout, next full sequence assembles correctly.
REQ-032 SHALL cover with FP_CLASSIFY_EN: a=0x7FF0000000000000, b=0x7FF8000000000000 -> a_class=011, b_class=100; a=0x0000000000000001, b=0x8000000000000000 -> a_class=001, b_class=000.
REQ-033 SHALL cover: in_valid toggling randomly for 1000 pairs against a reference model -> every pair delivered exactly once, in order, no err_timeout at TIMEOUT_CYCLES=255.

Source files
------------

// File: rtl/fp_operand_loader.sv
// Assembles four 32-bit words into an IEEE-754 double pair (a, b) for the adder stage.
// Define FP_CLASSIFY_EN to add the registered a_class/b_class outputs.
module fp_operand_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] a,
  output logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_timeout
`ifdef FP_CLASSIFY_EN
  ,
  output logic [2:0]  a_class,
  output logic [2:0]  b_class
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FULL = 2'd2} state_e;

  state_e           state_q;
  logic [1:0]       cnt_q;
  logic [7:0]       idle_q, idle_d;
  logic [2:0][31:0] buf_q;
  logic [63:0]      a_q, b_q, a_d, b_d;
  logic             ov_q, ir_q, err_q;
  logic             accept, timeout, last_word;

  assign accept    = in_valid && ir_q;
  assign last_word = (state_q == LOAD) && accept && (cnt_q == 2'd3);
  assign idle_d    = idle_q + 8'd1;
  // An accepted word wins over an expiring counter.
  assign timeout   = (state_q == LOAD) && !accept && (idle_d == 8'(TIMEOUT_CYCLES));
  // Partial words live in a shadow buffer so a/b only change when a pair completes.
  assign a_d = {buf_q[1], buf_q[0]};
  assign b_d = {in_data, buf_q[2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      idle_q  <= 8'd0;
      buf_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ov_q    <= 1'b0;
      ir_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ir_q <= 1'b1;
          if (accept) begin
            buf_q[0] <= in_data;
            cnt_q    <= 2'd1;
            idle_q   <= 8'd0;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          ir_q <= 1'b1;
          if (accept) begin
            idle_q <= 8'd0;
            if (cnt_q == 2'd3) begin
              a_q     <= a_d;
              b_q     <= b_d;
              ov_q    <= 1'b1;
              ir_q    <= 1'b0;
              cnt_q   <= 2'd0;
              state_q <= FULL;
            end else begin
              buf_q[cnt_q] <= in_data;
              cnt_q        <= cnt_q + 2'd1;
            end
          end else if (timeout) begin
            cnt_q   <= 2'd0;
            idle_q  <= 8'd0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            idle_q <= idle_d;
          end
        end
        FULL: begin
          if (out_ready) begin
            ov_q    <= 1'b0;
            ir_q    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 2'd0;
          idle_q  <= 8'd0;
          ov_q    <= 1'b0;
          ir_q    <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = ir_q;
  assign a           = a_q;
  assign b           = b_q;
  assign out_valid   = ov_q;
  assign err_timeout = err_q;

`ifdef FP_CLASSIFY_EN
  logic [2:0] ac_q, bc_q;

  // 000 zero, 001 subnormal, 010 normal, 011 inf, 100 qNaN, 101 sNaN
  function automatic logic [2:0] fp_class(input logic [63:0] v);
    logic [10:0] ex;
    logic [51:0] mt;
    ex = v[62:52];
    mt = v[51:0];
    if (ex == 11'd0)        return (mt == '0) ? 3'b000 : 3'b001;
    else if (ex == 11'h7FF) return (mt == '0) ? 3'b011 : (mt[51] ? 3'b100 : 3'b101);
    else                    return 3'b010;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac_q <= 3'b000;
      bc_q <= 3'b000;
    end else if (last_word) begin
      ac_q <= fp_class(a_d);
      bc_q <= fp_class(b_d);
    end
  end

  assign a_class = ac_q;
  assign b_class = bc_q;
`endif

endmodule

// File: tb/tb_fp_operand_loader.sv
// Bench for fp_operand_loader: directed handshake/timeout/reset cases plus 1000 random pairs.
module tb_fp_operand_loader;

  localparam logic [63:0] A12 = 64'h3FF3333333333333;
  localparam logic [63:0] B15 = 64'h3FF8000000000000;
  localparam logic [63:0] BN2 = 64'hC000000000000000;
  localparam logic [63:0] B3M = 64'h3F689374BC6A7EFA;
  localparam int NPAIR = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, err_timeout;
  logic [63:0] a, b;
  logic        t4_ir, t4_ov, t4_err;
  logic [63:0] t4_a, t4_b;
`ifdef FP_CLASSIFY_EN
  logic [2:0]  a_class, b_class, t4_ac, t4_bc;
`endif

  logic        use_t4 = 1'b0;
  int          nvec = 0;
  int          nerr = 0;
  logic [63:0] pa [NPAIR];
  logic [63:0] pb [NPAIR];

  always #5 clk = ~clk;

  fp_operand_loader u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .err_timeout(err_timeout)
`ifdef FP_CLASSIFY_EN
    , .a_class(a_class), .b_class(b_class)
`endif
  );

  fp_operand_loader #(.TIMEOUT_CYCLES(4)) u_t4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(t4_ir),
    .a(t4_a), .b(t4_b), .out_valid(t4_ov), .out_ready(out_ready), .err_timeout(t4_err)
`ifdef FP_CLASSIFY_EN
    , .a_class(t4_ac), .b_class(t4_bc)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the word was taken.
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!(use_t4 ? t4_ir : in_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("send_rdy", use_t4 ? t4_ir : in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic send_pair(input logic [63:0] pa_v, input logic [63:0] pb_v);
    send(pa_v[31:0]);
    send(pa_v[63:32]);
    send(pb_v[31:0]);
    send(pb_v[63:32]);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ir", in_ready, 1'b1);
  endtask

  // Reference word stream: pair p is a.lo, a.hi, b.lo, b.hi.
  function automatic logic [31:0] rword(input int i);
    logic [63:0] x;
    x = ((i % 4) < 2) ? pa[i / 4] : pb[i / 4];
    return (i % 2 == 0) ? x[31:0] : x[63:32];
  endfunction

  initial begin
    int wi, di, cyc;

    // reset state
    #12;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_a", a, 64'd0);
    chk("rst_b", b, 64'd0);
    chk("rst_err", err_timeout, 1'b0);
`ifdef FP_CLASSIFY_EN
    chk("rst_a_class", a_class, 3'b000);
    chk("rst_t4_b_class", t4_bc, 3'b000);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ir_after_rst", in_ready, 1'b1);

    // back-to-back pair 1.2 / 1.5
    out_ready = 1'b1;
    send(32'h33333333);
    send(32'h3FF33333);
    send(32'h00000000);
    chk("ov_before_w3", out_valid, 1'b0);
    send(32'h3FF80000);
    chk("ov_latency", out_valid, 1'b1);
    chk("a_1p2", a, A12);
    chk("b_1p5", b, B15);
    chk("ir_full", in_ready, 1'b0);
    @(negedge clk);
    chk("ov_after_hs", out_valid, 1'b0);
    chk("ir_after_hs", in_ready, 1'b1);
    chk("a_retained", a, A12);

    // stalled downstream with upstream pushing
    out_ready = 1'b0;
    send_pair(A12, BN2);
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    for (int k = 0; k < 10; k++) begin
      chk("stall_ov", out_valid, 1'b1);
      chk("stall_a", a, A12);
      chk("stall_b", b, BN2);
      chk("stall_ir", in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_release_ov", out_valid, 1'b0);
    chk("stall_release_ir", in_ready, 1'b1);
    send_pair(A12, B15);
    chk("post_stall_a", a, A12);
    chk("post_stall_b", b, B15);

    // timeout with TIMEOUT_CYCLES=4
    use_t4 = 1'b1;
    send(32'h33333333);
    send(32'h3FF33333);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("t4_err_idle%0d", k), t4_err, k == 4);
    end
    chk("t4_ir_after_to", t4_ir, 1'b1);
    send_pair(A12, B3M);
    chk("t4_fresh_ov", t4_ov, 1'b1);
    chk("t4_fresh_a", t4_a, A12);
    chk("t4_fresh_b", t4_b, B3M);
    do_reset();

    // acceptance in the would-be timeout cycle
    send(32'h33333333);
    send(32'h3FF33333);
    repeat (3) begin
      @(negedge clk);
      chk("prio_idle_err", t4_err, 1'b0);
    end
    send(32'h00000000);
    chk("prio_err", t4_err, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("prio_idle2_err", t4_err, 1'b0);
    end
    send(32'hC0000000);
    chk("prio_err2", t4_err, 1'b0);
    chk("prio_ov", t4_ov, 1'b1);
    chk("prio_a", t4_a, A12);
    chk("prio_b", t4_b, BN2);
    use_t4 = 1'b0;
    @(negedge clk);

    // reset mid-assembly
    send(32'h33333333);
    send(32'h3FF33333);
    send(32'h00000000);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ov", out_valid, 1'b0);
    chk("mid_rst_a", a, 64'd0);
    chk("mid_rst_b", b, 64'd0);
    chk("mid_rst_ir", in_ready, 1'b0);
    chk("mid_rst_err", err_timeout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ir_after", in_ready, 1'b1);
    chk("mid_rst_err_after", err_timeout | t4_err, 1'b0);
    send_pair(A12, B15);
    chk("mid_rst_pair_a", a, A12);
    chk("mid_rst_pair_b", b, B15);

`ifdef FP_CLASSIFY_EN
    send_pair(64'h7FF0000000000000, 64'h7FF8000000000000);
    chk("cls_inf", a_class, 3'b011);
    chk("cls_qnan", b_class, 3'b100);
    send_pair(64'h0000000000000001, 64'h8000000000000000);
    chk("cls_sub", a_class, 3'b001);
    chk("cls_zero", b_class, 3'b000);
    send_pair(A12, 64'h7FF0000000000001);
    chk("cls_normal", a_class, 3'b010);
    chk("cls_snan", b_class, 3'b101);
`endif

    // random traffic against the pair queue
    for (int p = 0; p < NPAIR; p++) begin
      pa[p] = {$urandom, $urandom};
      pb[p] = {$urandom, $urandom};
    end
    out_ready = 1'b0;
    do_reset();
    wi = 0;
    di = 0;
    cyc = 0;
    while (di < NPAIR && cyc < 40000) begin
      in_valid  = (wi < 4 * NPAIR) && ($urandom_range(0, 99) < 55);
      in_data   = in_valid ? rword(wi) : $urandom;
      out_ready = ($urandom_range(0, 1) == 1);
      chk("rnd_ir", in_ready, !out_valid);
      chk("rnd_err", err_timeout, 1'b0);
      if (out_valid && out_ready) begin
        chk($sformatf("rnd_a%0d", di), a, pa[di]);
        chk($sformatf("rnd_b%0d", di), b, pb[di]);
        di++;
      end
      if (in_valid && in_ready) wi++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_delivered", di, NPAIR);
    chk("rnd_words", wi, 4 * NPAIR);
    repeat (3) @(negedge clk);
    chk("rnd_no_extra", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
